// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcodes and multiplier-sequencer state encodings.
package alu_mul_seq_pkg;

  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_PASSB = 4'b0111;

  localparam logic [1:0] MS_IDLE  = 2'd0;
  localparam logic [1:0] MS_CHECK = 2'd1;
  localparam logic [1:0] MS_STEP  = 2'd2;
  localparam logic [1:0] MS_DONE  = 2'd3;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the execute-stage ALU as its adder,
// one ALU operation per cycle; returns the low WIDTH bits of MulA*MulB.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] MulA,
  input  logic [WIDTH-1:0] MulB,
  output logic [WIDTH-1:0] Product,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] AluW,
  input  logic             AluZero
);

  logic [1:0]       state;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] m_shr;

  assign m_shr = m >> 1;
  assign busy  = (state != MS_IDLE);
  assign done  = (state == MS_DONE);

  // NOTE: every output is given a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    AluCtrl = CTRL_PASSB;
    AluA    = '0;
    AluB    = '0;
    case (state)
      MS_CHECK: AluB = m;
      MS_STEP: begin
        AluCtrl = CTRL_ADD;
        AluA    = p;
        AluB    = m[0] ? d : '0;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; Reset is synchronous, so it only acts on a clock edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= MS_IDLE;
      d       <= '0;
      m       <= '0;
      p       <= '0;
      Product <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            d     <= MulA;
            m     <= MulB;
            p     <= '0;
            state <= MS_CHECK;
          end
        end
        MS_CHECK: begin
          // The ALU passes M through; its Zero flag tells us MulB was 0.
          if (AluZero) begin
            Product <= '0;
            state   <= MS_DONE;
          end else begin
            state <= MS_STEP;
          end
        end
        MS_STEP: begin
          p <= AluW;
          d <= d << 1;
          m <= m_shr;
          if (m_shr == '0) begin
            Product <= AluW;
            state   <= MS_DONE;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a combinational ALU model on the Alu* bus.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] mul_a, mul_b;
  logic [W-1:0] product;
  logic         busy, done;
  logic [W-1:0] alu_a, alu_b, alu_w;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(W)) dut (
    .CLK(clk), .Reset(reset), .start(start), .MulA(mul_a), .MulB(mul_b),
    .Product(product), .busy(busy), .done(done),
    .AluA(alu_a), .AluB(alu_b), .AluCtrl(alu_ctrl),
    .AluW(alu_w), .AluZero(alu_zero)
  );

  // Stand-in for the datapath ALU.
  always_comb begin
    alu_w = '0;
    case (alu_ctrl)
      CTRL_AND:   alu_w = alu_a & alu_b;
      CTRL_OR:    alu_w = alu_a | alu_b;
      CTRL_ADD:   alu_w = alu_a + alu_b;
      CTRL_SUB:   alu_w = alu_a - alu_b;
      CTRL_PASSB: alu_w = alu_b;
      default:    alu_w = '0;
    endcase
  end
  assign alu_zero = (alu_w == '0);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge; returns in cycle t+1.
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b1;
    start = 1'b0;
    mul_a = '0;
    mul_b = '0;
    step();
    step();
    check("rst_product", product, 0);
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_alua", alu_a, 0);
    check("rst_alub", alu_b, 0);
    check("rst_ctrl", W'(alu_ctrl), W'(CTRL_PASSB));
    reset = 1'b0;
    step();

    // 7 * 0: CHECK sees zero and goes straight to DONE.
    go(64'd7, 64'd0);
    check("z_check_ctrl", W'(alu_ctrl), W'(CTRL_PASSB));
    check("z_check_busy", W'(busy), 1);
    step();
    check("z_done", W'(done), 1);
    check("z_product", product, 0);
    step();
    check("z_idle_busy", W'(busy), 0);
    check("z_idle_done", W'(done), 0);

    // 0x1234 * 1: a single STEP.
    go(64'h1234, 64'd1);
    check("one_check_alub", alu_b, 1);
    step();
    check("one_step_ctrl", W'(alu_ctrl), W'(CTRL_ADD));
    check("one_step_alub", alu_b, 64'h1234);
    step();
    check("one_done", W'(done), 1);
    check("one_product", product, 64'h1234);
    step();

    // 13 * 11 (0b1011): k=4, AluB = 13, 26, 0, 104.
    go(64'd13, 64'd11);
    step();
    check("b_step1_ctrl", W'(alu_ctrl), W'(CTRL_ADD));
    check("b_step1_alub", alu_b, 13);
    step();
    check("b_step2_alub", alu_b, 26);
    check("b_step2_alua", alu_a, 13);
    step();
    check("b_step3_alub", alu_b, 0);
    step();
    check("b_step4_alub", alu_b, 104);
    check("b_step4_alua", alu_a, 39);
    step();
    check("b_done", W'(done), 1);
    check("b_product", product, 143);
    step();

    // All ones squared: worst-case latency, wraps to 1.
    go('1, '1);
    n = 1;
    while (!done && n < 200) begin
      step();
      n++;
    end
    check("ones_latency", W'(n), 66);
    check("ones_product", product, 1);
    step();

    // 6 * 6 with start pulsed in STEP and in DONE; then back-to-back 3 * 5.
    go(64'd6, 64'd6);
    step();
    mul_a = 64'd100;
    mul_b = 64'd100;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_step_alub", alu_b, 12);
    check("ign_step_busy", W'(busy), 1);
    step();
    check("ign_step3_alub", alu_b, 24);
    step();
    check("ign_done", W'(done), 1);
    check("ign_product", product, 36);
    mul_a = 64'd9;
    mul_b = 64'd9;
    start = 1'b1;
    step();
    check("ign_after_busy", W'(busy), 0);
    check("ign_after_product", product, 36);
    mul_a = 64'd3;
    mul_b = 64'd5;
    step();
    start = 1'b0;
    check("b2b_busy", W'(busy), 1);
    step();
    step();
    step();
    check("b2b_not_yet", W'(done), 0);
    step();
    check("b2b_done", W'(done), 1);
    check("b2b_product", product, 15);
    step();

    // Reset in the middle of a long multiply: back to IDLE, no done pulse.
    go('1, '1);
    repeat (9) step();
    check("rst_mid_busy_before", W'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", W'(busy), 0);
    check("rst_mid_done", W'(done), 0);
    check("rst_mid_product", product, 0);
    check("rst_mid_ctrl", W'(alu_ctrl), W'(CTRL_PASSB));
    seen = 0;
    repeat (80) begin
      step();
      if (done || busy) seen++;
    end
    check("rst_mid_quiet", W'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
